// File: rtl/tensor_core_pkg.sv
// Shared types for the tensor core scheduler: element/matrix layout and FSM states.
// Matrices are packed row-major, m[row][col], each element a signed BUS_WIDTH-bit value.
package tensor_core_pkg;

    localparam int BUS_WIDTH  = 4;
    localparam int MATRIX_DIM = 4;

    typedef logic signed [BUS_WIDTH-1:0] elem_t;
    typedef elem_t [MATRIX_DIM-1:0][MATRIX_DIM-1:0] matrix_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: combinational one-hot grant; the granted requester drops to
// lowest priority when advance is pulsed. Priority pointer starts at requester 0.
module round_robin_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    localparam int SW = IDX_W + 1;

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    always_comb begin
        logic             found;
        logic [SW-1:0]    sum;
        logic [IDX_W-1:0] idx;
        grant     = '0;
        grant_idx = ptr_q;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        // Scan starting at the pointer, wrapping modulo NUM_REQ.
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + SW'(i);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tensor_core_scheduler.sv
// Shares one tensor core among NUM_REQ requesters, one job at a time: grant, load pulse,
// wait for done (or timeout), then hold the response until the consumer takes it.
module tensor_core_scheduler
    import tensor_core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int NUM_REQ        = 2
) (
    input  logic                       clock_in,
    input  logic                       reset_in,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  matrix_t [NUM_REQ-1:0]      req_matrix_a,
    input  matrix_t [NUM_REQ-1:0]      req_matrix_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       resp_valid,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output matrix_t                    resp_matrix,
    output logic                       resp_error,
    input  logic                       resp_ready,
    output logic                       core_write_enable,
    output matrix_t                    core_input1,
    output matrix_t                    core_input2,
    input  matrix_t                    core_output,
    input  logic                       core_done
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    matrix_t           op_a_q, op_a_d;
    matrix_t           op_b_q, op_b_d;
    logic [ID_W-1:0]   id_q, id_d;
    matrix_t           res_q, res_d;
    logic              err_q, err_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               accept;

    round_robin_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clock_in),
        .rst       (reset_in),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grants are masked during reset so no output is live while reset_in is high.
    assign req_ready         = (state_q == ST_IDLE && !reset_in) ? grant : '0;
    assign accept            = |(req_ready & req_valid);
    assign resp_valid        = (state_q == ST_RESPOND);
    assign core_write_enable = (state_q == ST_LOAD);
    assign core_input1       = op_a_q;
    assign core_input2       = op_b_q;
    assign resp_id           = id_q;
    assign resp_matrix       = res_q;
    assign resp_error        = err_q;
    assign cnt_inc           = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        id_d    = id_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    op_a_d  = req_matrix_a[grant_idx];
                    op_b_d  = req_matrix_b[grant_idx];
                    id_d    = grant_idx;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                cnt_d = cnt_inc;
                // A done on the first COMPUTE cycle belongs to the previous job.
                if (core_done && cnt_q != '0) begin
                    res_d   = core_output;
                    err_d   = 1'b0;
                    state_d = ST_RESPOND;
                end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            id_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            id_q    <= id_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// Bench for tensor_core_scheduler: behavioural core model plus a job-level reference
// (round-robin pick, done/timeout latency rule, product or zero/error response).
module tb_tensor_core_scheduler;
    import tensor_core_pkg::*;

    localparam int T = 40;

    logic          clk;
    logic          rst;
    logic [1:0]    req_valid;
    matrix_t [1:0] req_matrix_a;
    matrix_t [1:0] req_matrix_b;
    logic [1:0]    req_ready;
    logic          resp_valid;
    logic [0:0]    resp_id;
    matrix_t       resp_matrix;
    logic          resp_error;
    logic          resp_ready;
    logic          core_write_enable;
    matrix_t       core_input1;
    matrix_t       core_input2;
    matrix_t       core_output;
    logic          core_done;

    logic [63:0] done_mask;
    int          phase;
    int          total;
    int          bad;
    int          rr_ptr;

    tensor_core_scheduler #(
        .TIMEOUT_CYCLES (T),
        .NUM_REQ        (2)
    ) dut (
        .clock_in          (clk),
        .reset_in          (rst),
        .req_valid         (req_valid),
        .req_matrix_a      (req_matrix_a),
        .req_matrix_b      (req_matrix_b),
        .req_ready         (req_ready),
        .resp_valid        (resp_valid),
        .resp_id           (resp_id),
        .resp_matrix       (resp_matrix),
        .resp_error        (resp_error),
        .resp_ready        (resp_ready),
        .core_write_enable (core_write_enable),
        .core_input1       (core_input1),
        .core_input2       (core_input2),
        .core_output       (core_output),
        .core_done         (core_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic matrix_t matmul(input matrix_t a, input matrix_t b);
        matrix_t r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 4; k++) begin
                    s += int'($signed(a[i][k])) * int'($signed(b[k][j]));
                end
                r[i][j] = elem_t'(s);
            end
        end
        return r;
    endfunction

    // Index of the done pulse that the scheduler should honour, -1 if it must time out.
    // Index 0 is the load cycle, index n>0 is compute cycle n-1.
    function automatic int capture_pos(input logic [63:0] m);
        for (int p = 2; p <= T; p++) begin
            if (m[p]) return p;
        end
        return -1;
    endfunction

    function automatic int rr_pick(input logic [1:0] vp);
        for (int k = 0; k < 2; k++) begin
            int idx;
            idx = (rr_ptr + k) % 2;
            if (vp[idx]) return idx;
        end
        return -1;
    endfunction

    // Tensor core model: done pattern indexed by cycles since the load pulse.
    initial begin
        core_done   = 1'b0;
        core_output = '0;
        phase       = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                phase     = -1;
                core_done = 1'b0;
            end else begin
                if (core_write_enable) phase = 0;
                if (phase >= 0 && phase < 64) begin
                    core_done   = done_mask[phase];
                    core_output = matmul(core_input1, core_input2);
                    phase++;
                end else begin
                    core_done = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_mats();
        req_matrix_a = {$urandom(), $urandom(), $urandom(), $urandom()};
        req_matrix_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic accept(input logic [1:0] vp, output int id, output matrix_t a, output matrix_t b);
        logic [1:0] g;
        id = rr_pick(vp);
        a  = req_matrix_a[id];
        b  = req_matrix_b[id];
        g  = 2'b01 << id;
        req_valid = vp;
        #1;
        check("grant", req_ready, g);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rr_ptr    = (id + 1) % 2;
        set_mats();
    endtask

    task automatic finish_job(input int id, input logic [63:0] mask, input int bp,
                              input matrix_t a, input matrix_t b);
        int      p, lat, n, we_cnt;
        bit      seen;
        matrix_t er;
        logic    ee;
        p   = capture_pos(mask);
        lat = (p < 0) ? T + 1 : p + 1;
        ee  = (p < 0);
        er  = ee ? matrix_t'(0) : matmul(a, b);
        resp_ready = (bp == 0);
        n = 0; we_cnt = 0; seen = 1'b0;
        while (!seen && n <= T + 10) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
            else begin
                we_cnt += int'(core_write_enable);
                n++;
            end
        end
        check("resp_seen", seen, 1'b1);
        check("latency", n, lat);
        check("we_pulses", we_cnt, 1);
        check("resp_id", resp_id, id);
        check("resp_matrix", resp_matrix, er);
        check("resp_error", resp_error, ee);
        check("core_input1", core_input1, a);
        check("core_input2", core_input2, b);
        if (bp > 0) begin
            req_valid = 2'b11;
            for (int k = 0; k < bp; k++) begin
                @(negedge clk);
                check("bp_valid", resp_valid, 1'b1);
                check("bp_matrix", resp_matrix, er);
                check("bp_error", resp_error, ee);
                check("bp_req_ready", req_ready, 2'b00);
            end
            resp_ready = 1'b1;
        end
        @(negedge clk);
        check("resp_released", resp_valid, 1'b0);
        req_valid  = 2'b00;
        resp_ready = 1'b0;
    endtask

    task automatic run_job(input logic [1:0] vp, input logic [63:0] mask, input int bp);
        int      id;
        matrix_t a, b;
        done_mask = mask;
        accept(vp, id, a, b);
        finish_job(id, mask, bp, a, b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        rr_ptr = 0;
    endtask

    initial begin
        int          id;
        matrix_t     a, b, ident, twos;
        logic [63:0] m;
        logic        any_v;
        total = 0; bad = 0; rr_ptr = 0;
        rst = 1'b1; req_valid = 2'b11; resp_ready = 1'b0; done_mask = '0;
        set_mats();
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_we", core_write_enable, 1'b0);
        check("rst_in1", core_input1, 64'h0);
        check("rst_in2", core_input2, 64'h0);
        check("rst_matrix", resp_matrix, 64'h0);
        check("rst_id", resp_id, 1'b0);
        check("rst_error", resp_error, 1'b0);
        rst = 1'b0; req_valid = 2'b00;
        @(negedge clk);

        // Contention: both requesting, grants must alternate 0,1,0.
        for (int k = 0; k < 3; k++) begin
            set_mats();
            run_job(2'b11, 64'(1) << (3 + k), 0);
        end

        // Identity times all-2 from requester 0.
        do_reset();
        ident = '0;
        for (int i = 0; i < 4; i++) ident[i][i] = elem_t'(1);
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) twos[i][j] = elem_t'(2);
        req_matrix_a[0] = ident;
        req_matrix_b[0] = twos;
        done_mask = 64'(1) << 4;
        accept(2'b01, id, a, b);
        finish_job(id, 64'(1) << 4, 0, a, b);
        check("ident_matrix", resp_matrix, twos);

        run_job(2'b10, 64'h0, 0);                           // timeout
        run_job(2'b01, 64'(1) << 6, 5);                     // backpressure
        run_job(2'b10, 64'h3 | (64'(1) << 7), 0);           // stale done in load/first compute
        run_job(2'b01, 64'h6, 0);                           // earliest honoured done

        // Reset in the middle of a compute phase.
        set_mats();
        done_mask = '0;
        accept(2'b01, id, a, b);
        repeat (6) @(negedge clk);
        req_valid = 2'b11;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", resp_valid, 1'b0);
        check("mid_rst_we", core_write_enable, 1'b0);
        check("mid_rst_ready", req_ready, 2'b00);
        check("mid_rst_in1", core_input1, 64'h0);
        check("mid_rst_in2", core_input2, 64'h0);
        check("mid_rst_matrix", resp_matrix, 64'h0);
        check("mid_rst_error", resp_error, 1'b0);
        @(negedge clk);
        rst = 1'b0; req_valid = 2'b00; rr_ptr = 0;
        any_v = 1'b0;
        repeat (T + 5) begin
            @(negedge clk);
            any_v = any_v | resp_valid | core_write_enable;
        end
        check("no_stale_resp", any_v, 1'b0);
        set_mats();
        run_job(2'b11, 64'(1) << 5, 0);

        // Randomized jobs.
        repeat (25) begin
            int          p;
            logic [1:0]  vp;
            vp = 2'($urandom_range(1, 3));
            p  = $urandom_range(2, T + 4);
            m  = 64'(1) << p;
            m  = m | 64'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) m = m | (64'(1) << (p + $urandom_range(1, 5)));
            set_mats();
            run_job(vp, m, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
